// File: rtl/alu_pkg.sv
// Shared ALU types: operation codes, default datapath width and muldiv FSM states.
package alu_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    typedef enum logic [4:0] {
        AluAdd    = 5'b00000,
        AluSub    = 5'b00001,
        AluAnd    = 5'b00010,
        AluOr     = 5'b00011,
        AluXor    = 5'b00100,
        AluSll    = 5'b00101,
        AluSrl    = 5'b00110,
        AluSra    = 5'b00111,
        AluSlt    = 5'b01000,
        AluSltu   = 5'b01001,
        AluLui    = 5'b01010,
        AluMul    = 5'b10100,
        AluMulh   = 5'b10101,
        AluMulhsu = 5'b10110,
        AluMulhu  = 5'b10111,
        AluDiv    = 5'b11000,
        AluDivu   = 5'b11001,
        AluRem    = 5'b11010,
        AluRemu   = 5'b11011
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// One radix-2 step per enable: shift-add multiply or restoring shift-subtract divide.
// Divider step is present only when ALU_MULDIV_DIV_EN is defined.
module muldiv_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              en,
    input  logic              is_div,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [2*XLEN-1:0] acc_nxt
);
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN:0]     sum;
`ifdef ALU_MULDIV_DIV_EN
    logic [XLEN:0]     diff;
`else
    logic              unused_div;
    assign unused_div = is_div;
`endif

    // Multiply: upper half accumulates, multiplier bits retire from the bottom.
    // Divide: remainder in the upper half, quotient bits shift in at the bottom.
    always_comb begin
        sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b} : '0);
        acc_nxt = {sum, acc_q[XLEN-1:1]};
`ifdef ALU_MULDIV_DIV_EN
        diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b};
        if (is_div) begin
            acc_nxt = diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                 : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (load) begin
            acc_q <= {{XLEN{1'b0}}, a};
        end else if (en) begin
            acc_q <= acc_nxt;
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit with valid/ready handshake and flush.
// Division codes are supported only when ALU_MULDIV_DIV_EN is defined.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT,
    parameter int unsigned OPW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [OPW-1:0]  alu_control,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal_op,
    output logic            busy
);
    localparam int unsigned CW = $clog2(XLEN) + 1;

    muldiv_state_e     state;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   res_q, mag_b_q;
    logic              ill_q, hi_q, neg_q;

    logic              dec_legal, dec_hi, sa, sb, special, accept, start, step_en, is_div;
    logic [XLEN-1:0]   spec_res, mag_a, mag_b, fin_res;
    logic [2*XLEN-1:0] acc_nxt, prod;
`ifdef ALU_MULDIV_DIV_EN
    logic              dec_div, dec_rem, dec_sgn, div_q, rem_q, rneg_q;
    logic [XLEN-1:0]   quo, rem;
`endif

    always_comb begin
        dec_legal = 1'b0;
        dec_hi    = 1'b0;
        sa        = 1'b0;
        sb        = 1'b0;
        special   = 1'b0;
        spec_res  = '0;
`ifdef ALU_MULDIV_DIV_EN
        dec_div   = 1'b0;
        dec_rem   = 1'b0;
        dec_sgn   = 1'b0;
`endif
        case (alu_control)
            OPW'(AluMul):    dec_legal = 1'b1;
            OPW'(AluMulh):   begin dec_legal = 1'b1; dec_hi = 1'b1;
                                   sa = op1[XLEN-1]; sb = op2[XLEN-1]; end
            OPW'(AluMulhsu): begin dec_legal = 1'b1; dec_hi = 1'b1; sa = op1[XLEN-1]; end
            OPW'(AluMulhu):  begin dec_legal = 1'b1; dec_hi = 1'b1; end
`ifdef ALU_MULDIV_DIV_EN
            OPW'(AluDiv):    begin dec_legal = 1'b1; dec_div = 1'b1; dec_sgn = 1'b1; end
            OPW'(AluDivu):   begin dec_legal = 1'b1; dec_div = 1'b1; end
            OPW'(AluRem):    begin dec_legal = 1'b1; dec_div = 1'b1; dec_rem = 1'b1;
                                   dec_sgn = 1'b1; end
            OPW'(AluRemu):   begin dec_legal = 1'b1; dec_div = 1'b1; dec_rem = 1'b1; end
`endif
            default: ;
        endcase
`ifdef ALU_MULDIV_DIV_EN
        if (dec_sgn) begin
            sa = op1[XLEN-1];
            sb = op2[XLEN-1];
        end
        // Divide-by-zero and signed overflow resolve without iterating.
        if (dec_div && op2 == '0) begin
            special  = 1'b1;
            spec_res = dec_rem ? op1 : '1;
        end else if (dec_sgn && op1 == {1'b1, {(XLEN-1){1'b0}}} && op2 == '1) begin
            special  = 1'b1;
            spec_res = dec_rem ? '0 : op1;
        end
`endif
        mag_a = sa ? -op1 : op1;
        mag_b = sb ? -op2 : op2;
    end

    assign accept  = in_valid & in_ready & ~flush;
    assign start   = accept & dec_legal & ~special;
    assign step_en = (state == StCalc) & ~flush;
`ifdef ALU_MULDIV_DIV_EN
    assign is_div  = div_q;
`else
    assign is_div  = 1'b0;
`endif

    muldiv_iter #(
        .XLEN(XLEN)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (start),
        .en     (step_en),
        .is_div (is_div),
        .a      (mag_a),
        .b      (mag_b_q),
        .acc_nxt(acc_nxt)
    );

    // Sign correction is folded into the last iteration's result.
    always_comb begin
        prod    = neg_q ? -acc_nxt : acc_nxt;
        fin_res = hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
`ifdef ALU_MULDIV_DIV_EN
        quo = acc_nxt[XLEN-1:0];
        rem = acc_nxt[2*XLEN-1:XLEN];
        if (div_q) begin
            fin_res = rem_q ? (rneg_q ? -rem : rem) : (neg_q ? -quo : quo);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= StIdle;
            cnt     <= '0;
            res_q   <= '0;
            ill_q   <= 1'b0;
            hi_q    <= 1'b0;
            neg_q   <= 1'b0;
            mag_b_q <= '0;
`ifdef ALU_MULDIV_DIV_EN
            div_q   <= 1'b0;
            rem_q   <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else if (flush) begin
            state <= StIdle;
            cnt   <= '0;
            res_q <= '0;
            ill_q <= 1'b0;
        end else begin
            case (state)
                StIdle: if (in_valid) begin
                    cnt   <= '0;
                    ill_q <= ~dec_legal;
                    if (!dec_legal || special) begin
                        state <= StDone;
                        res_q <= spec_res;
                    end else begin
                        state   <= StCalc;
                        hi_q    <= dec_hi;
                        neg_q   <= sa ^ sb;
                        mag_b_q <= mag_b;
`ifdef ALU_MULDIV_DIV_EN
                        div_q   <= dec_div;
                        rem_q   <= dec_rem;
                        rneg_q  <= sa;
`endif
                    end
                end
                StCalc: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(XLEN - 1)) begin
                        state <= StDone;
                        res_q <= fin_res;
                    end
                end
                StDone: if (out_ready) state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    assign in_ready   = (state == StIdle);
    assign busy       = (state != StIdle);
    assign out_valid  = (state == StDone);
    assign result     = res_q;
    assign illegal_op = ill_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed scoreboard bench for alu_muldiv; expectations follow ALU_MULDIV_DIV_EN.
module tb_alu_muldiv;
    localparam logic [4:0] OpMul = 5'b10100, OpMulh = 5'b10101, OpMulhsu = 5'b10110,
                           OpMulhu = 5'b10111, OpDiv = 5'b11000, OpDivu = 5'b11001,
                           OpRem = 5'b11010, OpRemu = 5'b11011;

    typedef struct packed {
        logic [31:0] res;
        logic        ill;
        logic [7:0]  lat;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [31:0] op1 = '0, op2 = '0;
    logic [4:0]  alu_control = '0;
    logic        in_ready, out_valid, illegal_op, busy;
    logic [31:0] result;

    exp_t sb_q[$];
    int   nerr = 0, nchk = 0;

    alu_muldiv #(.XLEN(32), .OPW(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .alu_control(alu_control), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .illegal_op(illegal_op), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, b);
        exp_t               e;
        logic [63:0]        ea, eb, p;
        logic signed [31:0] sa_v, sb_v;
        e.res = '0; e.ill = 1'b0; e.lat = 8'd33;
        sa_v = a; sb_v = b;
        ea = {32'b0, a}; eb = {32'b0, b};
        if (op == OpMulh || op == OpMulhsu) ea = {{32{a[31]}}, a};
        if (op == OpMulh) eb = {{32{b[31]}}, b};
        p = ea * eb;
        case (op)
            OpMul: e.res = p[31:0];
            OpMulh, OpMulhsu, OpMulhu: e.res = p[63:32];
`ifdef ALU_MULDIV_DIV_EN
            OpDiv:
                if (b == 0) begin e.res = '1; e.lat = 8'd1; end
                else if (a == 32'h8000_0000 && b == '1) begin e.res = a; e.lat = 8'd1; end
                else e.res = sa_v / sb_v;
            OpDivu:
                if (b == 0) begin e.res = '1; e.lat = 8'd1; end
                else e.res = a / b;
            OpRem:
                if (b == 0) begin e.res = a; e.lat = 8'd1; end
                else if (a == 32'h8000_0000 && b == '1) begin e.res = '0; e.lat = 8'd1; end
                else e.res = sa_v % sb_v;
            OpRemu:
                if (b == 0) begin e.res = a; e.lat = 8'd1; end
                else e.res = a % b;
`endif
            default: begin e.ill = 1'b1; e.lat = 8'd1; end
        endcase
        return e;
    endfunction

    // Starts and ends on a falling edge.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a, b,
                          input int hold);
        exp_t e;
        int   lat;
        sb_q.push_back(model(op, a, b));
        check({tag, ".in_ready_pre"}, in_ready, 1);
        in_valid = 1'b1; op1 = a; op2 = b; alu_control = op;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; op1 = $urandom; op2 = $urandom; alu_control = 5'($urandom);
        check({tag, ".busy"}, busy, 1);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        e = sb_q.pop_front();
        check({tag, ".latency"}, 64'(lat), 64'(e.lat));
        check({tag, ".result"}, result, e.res);
        check({tag, ".illegal"}, illegal_op, e.ill);
        repeat (hold) begin
            @(negedge clk);
            check({tag, ".hold_result"}, result, e.res);
            check({tag, ".hold_valid"}, out_valid, 1);
            check({tag, ".hold_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".in_ready_post"}, in_ready, 1);
    endtask

    initial begin
        int vcount;
        logic [4:0] rop;
        repeat (2) @(negedge clk);
        check("rst.in_ready", in_ready, 1);
        check("rst.out_valid", out_valid, 0);
        check("rst.result", result, 0);
        check("rst.illegal", illegal_op, 0);
        check("rst.busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("mul_7x-3", OpMul, 32'h0000_0007, 32'hFFFF_FFFD, 5);
        check("mul_7x-3.value", result, 32'hFFFF_FFEB);
        run_op("mulhu_ff", OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mulh_ff", OpMulh, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mulhsu_ff", OpMulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("div_-7_2", OpDiv, 32'hFFFF_FFF9, 32'h0000_0002, 0);
        run_op("rem_-7_2", OpRem, 32'hFFFF_FFF9, 32'h0000_0002, 0);
        run_op("divu_by0", OpDivu, 32'd100, 32'd0, 0);
        run_op("remu_by0", OpRemu, 32'd100, 32'd0, 0);
        run_op("rem_ovf", OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("illegal_sub", 5'b00001, 32'd5, 32'd6, 0);
        for (int i = 0; i < 8; i++) begin
            rop = 5'(5'b10100 + 5'(i));
            run_op("rand", rop, $urandom, (i == 7) ? 32'(-3) : $urandom, 0);
        end

        // Flush mid-calculation.
        in_valid = 1'b1; op1 = 32'd100; op2 = 32'd7;
`ifdef ALU_MULDIV_DIV_EN
        alu_control = OpDivu;
`else
        alu_control = OpMulhu;
`endif
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        vcount = 0;
        for (int c = 1; c < 10; c++) begin
            vcount += int'(out_valid);
            @(negedge clk);
        end
        vcount += int'(out_valid);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush.no_valid", 64'(vcount + int'(out_valid)), 0);
        check("flush.busy", busy, 0);
        check("flush.in_ready", in_ready, 1);
        run_op("mul_3x4", OpMul, 32'd3, 32'd4, 0);
        check("mul_3x4.value", result, 32'd12);

        // Asynchronous reset mid-calculation.
        in_valid = 1'b1; op1 = 32'd5; op2 = 32'd6; alu_control = OpMul;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst.in_ready", in_ready, 1);
        check("arst.out_valid", out_valid, 0);
        check("arst.result", result, 0);
        check("arst.illegal", illegal_op, 0);
        check("arst.busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        vcount = 0;
        repeat (35) begin
            @(negedge clk);
            vcount += int'(out_valid);
        end
        check("arst.no_stale_valid", 64'(vcount), 0);
        run_op("code0", 5'b00000, 32'd9, 32'd9, 0);
        run_op("div_after_rst", OpDiv, 32'd50, 32'd7, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised iterative multiply/divide unit for the RV32M operations, sitting beside the single-cycle `alu` in the execute stage. It accepts one operation at a time over a valid/ready handshake, computes it with a radix-2 shift-add / shift-subtract datapath over XLEN cycles, and holds the result until the pipeline consumes it. Division-by-zero and signed overflow resolve early. A flush aborts any in-flight operation.

## Interface
Parameters:
- `XLEN`, 32: operand/result width; even, ≥ 8.
- `OPW`, 5: width of `alu_control`.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: operation request.
- `in_ready` out 1: unit can accept a request (state IDLE).
- `op1` in XLEN: rs1 operand.
- `op2` in XLEN: rs2 operand.
- `alu_control` in OPW: operation code (`alu_pkg::alu_op_e`).
- `flush` in 1: synchronous abort.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts the result.
- `result` out XLEN: operation result.
- `illegal_op` out 1: the accepted code was not an M operation; qualified by `out_valid`.
- `busy` out 1: state ≠ IDLE.

## Operation
- Codes: 10100 MUL, 10101 MULH, 10110 MULHSU, 10111 MULHU, 11000 DIV, 11001 DIVU, 11010 REM, 11011 REMU.
- FSM states:
  - IDLE → CALC on accept (`in_valid & in_ready & !flush`).
  - IDLE → DONE on accept of a special case or illegal code.
  - CALC → DONE when the iteration counter reaches XLEN.
  - DONE → IDLE on `out_ready`.
- `op1`, `op2` and `alu_control` are latched at accept. Later input changes are ignored.
- Signed operations work on magnitudes. Sign correction is applied in the final CALC cycle.
  - MULHSU treats `op1` as signed and `op2` as unsigned.
  - Quotient sign = sign(op1) XOR sign(op2). Remainder sign = sign(op1).
- MUL returns product[XLEN-1:0]. MULH, MULHSU and MULHU return product[2·XLEN-1:XLEN] of the full 2·XLEN-bit product.
- Special cases (no CALC):
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give `op1`.
  - DIV of −2^(XLEN-1) by −1: quotient = `op1`, REM = 0.
- Illegal code: result 0, `illegal_op` = 1.
- `flush` in any state returns the FSM to IDLE next cycle and discards the result. In IDLE, `flush` blocks acceptance the same cycle.

## Timing
- Reset values: state IDLE, `in_ready` 1, `out_valid` 0, `result` 0, `illegal_op` 0, `busy` 0, counter 0.
- Normal operation: accept at cycle T → `out_valid` at T+XLEN+1 (33 for XLEN=32).
- Special case or illegal code: `out_valid` at T+1.
- `result` and `illegal_op` are registered and stable while `out_valid` = 1 and `out_ready` = 0.
- `in_ready` is low from the cycle after accept until the cycle after the result handshake. No back-to-back acceptance in the same cycle as `out_valid & out_ready`.
- Counter width is $clog2(XLEN)+1. It clears at accept and never wraps within an operation.
- Reset asserted mid-operation clears all state immediately (asynchronous). No stale `out_valid` after release.

## Configuration
- `ALU_MULDIV_DIV_EN` defined:
  - All eight codes are supported.
  - The divider datapath and special-case logic are compiled in.
- `ALU_MULDIV_DIV_EN` undefined:
  - Codes 11000–11011 are treated as illegal: 1-cycle, result 0, `illegal_op` = 1.
  - No subtractor/remainder register is synthesised.
  - The multiply path is unchanged.

## Structure
- `alu_pkg` holds:
  - `alu_op_e` with all ALU and M codes.
  - The `XLEN_DEFAULT` constant.
  - The `muldiv_state_e` (IDLE, CALC, DONE) typedef.
- Sub-module `muldiv_iter`: per-step datapath, one shift-add (multiply) or shift-subtract (restoring divide) per enable, 2·XLEN accumulator. `alu_muldiv` owns the FSM, handshake, sign handling and special cases.

## Test plan
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD) → result 0xFFFFFFEB at T+33, `illegal_op` 0.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH on the same operands → 0x00000000. MULHSU on the same operands → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD, and REM → 0xFFFFFFFF. DIVU 100 / 0 → 0xFFFFFFFF at T+1. REM 0x80000000 / 0xFFFFFFFF → 0 at T+1.
- Hold `out_ready` = 0 for 5 cycles after `out_valid`. `result` stays constant, and `in_ready` stays 0 until the handshake.
- Assert `flush` at T+10 of a DIVU. `out_valid` never rises, the unit is IDLE at T+11, and a new MUL 3×4 accepted at T+11 returns 12.
- Assert `rst_n` low mid-CALC for 1 cycle. All outputs are at reset values. Code 00000 then returns result 0, `illegal_op` 1 at T+1. Without `ALU_MULDIV_DIV_EN`, DIV does the same.
